// File: rtl/panel_pkg.sv
// ----------------------------------------------------------------------------
// panel_pkg
// Shared definitions for the front-panel keyboard cursor:
//   - switch action encodings driven on cursor_action
//   - PS/2 scancodes recognised by the cursor logic
//   - bit positions inside the 11-bit ps2_key bus
//   - cursor state encoding
// ----------------------------------------------------------------------------
package panel_pkg;

    typedef enum logic [1:0] {
        ACT_DOWN = 2'd0,
        ACT_UP   = 2'd1,
        ACT_AUX  = 2'd2,
        ACT_MOVE = 2'd3
    } action_t;

    typedef enum logic {
        ST_IDLE,
        ST_HELD
    } state_t;

    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_0     = 8'h45;
    localparam logic [7:0] SC_1     = 8'h16;
    localparam logic [7:0] SC_2     = 8'h1E;

    localparam int unsigned PS2_W    = 11;
    localparam int unsigned PS2_EXT  = 8;
    localparam int unsigned PS2_MAKE = 9;
    localparam int unsigned PS2_TOG  = 10;

endpackage

// File: rtl/ps2_event_detect.sv
// ----------------------------------------------------------------------------
// ps2_event_detect
// Registers the PS/2 key bus and flags one event per change of the toggle bit.
// Ports:
//   i_clk      system clock
//   i_reset_n  synchronous reset, active-low
//   i_ps2_key  [7:0] scancode, [8] extended, [9] make, [10] event toggle
//   o_event    high for the cycle in which a new key event is presented
//   o_make     1 = make (press), 0 = break (release)
//   o_ext      extended-key flag
//   o_code     scancode
// ----------------------------------------------------------------------------
module ps2_event_detect
    import panel_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic [PS2_W-1:0] i_ps2_key,
    output logic             o_event,
    output logic             o_make,
    output logic             o_ext,
    output logic [7:0]       o_code
);

    logic [PS2_W-1:0] r_key_q;
    logic             r_tog_d;

    // During reset the toggle history is seeded straight from the bus so the
    // first cycle after reset sees no spurious event.
    always_ff @(posedge i_clk) begin
        r_key_q <= i_ps2_key;
        if (!i_reset_n) begin
            r_tog_d <= i_ps2_key[PS2_TOG];
        end else begin
            r_tog_d <= r_key_q[PS2_TOG];
        end
    end

    assign o_event = r_key_q[PS2_TOG] ^ r_tog_d;
    assign o_make  = r_key_q[PS2_MAKE];
    assign o_ext   = r_key_q[PS2_EXT];
    assign o_code  = r_key_q[7:0];

endmodule

// File: rtl/panel_cursor.sv
// ----------------------------------------------------------------------------
// panel_cursor
// Keyboard-driven cursor over the front-panel switch grid. Arrow keys move a
// row/column cursor; keys 0/1/2 issue down/up/aux actions for the switch under
// the cursor. Momentary switches hold their action until the same key is
// released, then fall back to down.
// Ports:
//   clk            system clock
//   reset_n        synchronous reset, active-low
//   ps2_key        [7:0] scancode, [8] extended, [9] make, [10] event toggle
//   cursor_index   row*COLS+col
//   cursor_row     current row
//   cursor_col     current column
//   cursor_action  0=down 1=up 2=aux 3=move/none
//   action_strobe  one-cycle pulse when action or index changes
//   held           a momentary action is latched
// ----------------------------------------------------------------------------
module panel_cursor
    import panel_pkg::*;
#(
    parameter int unsigned COLS           = 16,
    parameter int unsigned ROWS           = 2,
    parameter int unsigned IDX_W          = 5,
    parameter int unsigned LAST_INDEX     = 24,
    parameter logic [31:0] MOMENTARY_MASK = 32'h007C_0000,
    parameter logic        WRAP           = 1'b0,
    parameter logic        REQUIRE_EXT    = 1'b1
) (
    input  logic                                  clk,
    input  logic                                  reset_n,
    input  logic [10:0]                           ps2_key,
    output logic [IDX_W-1:0]                      cursor_index,
    output logic [((ROWS > 1) ? $clog2(ROWS) : 1)-1:0] cursor_row,
    output logic [((COLS > 1) ? $clog2(COLS) : 1)-1:0] cursor_col,
    output logic [1:0]                            cursor_action,
    output logic                                  action_strobe,
    output logic                                  held
);

    localparam int unsigned ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned COL_W = (COLS > 1) ? $clog2(COLS) : 1;

    logic             w_event;
    logic             w_make;
    logic             w_ext;
    logic [7:0]       w_code;

    logic [ROW_W-1:0] r_row;
    logic [COL_W-1:0] r_col;
    action_t          r_action;
    state_t           r_state;
    logic             r_held_key2;   // 0 = key 1 held, 1 = key 2 held
    logic             r_strobe;
    logic             r_held;

    logic [31:0]      w_trow;
    logic [31:0]      w_tcol;
    logic [ROW_W-1:0] w_nrow;
    logic [COL_W-1:0] w_ncol;
    action_t          w_nact;
    state_t           w_nstate;
    logic             w_nheld_key2;
    logic [IDX_W-1:0] w_cur_idx;
    logic [IDX_W-1:0] w_nidx;
    logic             w_arrow_ok;
    logic             w_momentary;

    ps2_event_detect u_evt (
        .i_clk     (clk),
        .i_reset_n (reset_n),
        .i_ps2_key (ps2_key),
        .o_event   (w_event),
        .o_make    (w_make),
        .o_ext     (w_ext),
        .o_code    (w_code)
    );

    // Last reachable column of a row; only called for reachable rows.
    function automatic logic [31:0] f_last_col(input logic [31:0] row);
        logic [31:0] rem;
        rem = LAST_INDEX - row * COLS;
        return (rem < COLS - 32'd1) ? rem : COLS - 32'd1;
    endfunction

    assign w_cur_idx   = IDX_W'(32'(r_row) * COLS + 32'(r_col));
    assign w_nidx      = IDX_W'(32'(w_nrow) * COLS + 32'(w_ncol));
    assign w_arrow_ok  = w_ext | ~REQUIRE_EXT;
    assign w_momentary = |(MOMENTARY_MASK & (32'd1 << w_cur_idx));

    always_comb begin
        w_trow       = 32'(r_row);
        w_tcol       = 32'(r_col);
        w_nact       = r_action;
        w_nstate     = r_state;
        w_nheld_key2 = r_held_key2;
        if (w_event) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_make) begin
                        case (w_code)
                            SC_UP: if (w_arrow_ok) begin
                                w_nact = ACT_MOVE;
                                if (w_trow != 32'd0) w_trow = w_trow - 32'd1;
                            end
                            SC_DOWN: if (w_arrow_ok) begin
                                w_nact = ACT_MOVE;
                                if ((w_trow + 32'd1 < ROWS) &&
                                    ((w_trow + 32'd1) * COLS <= LAST_INDEX))
                                    w_trow = w_trow + 32'd1;
                            end
                            SC_LEFT: if (w_arrow_ok) begin
                                w_nact = ACT_MOVE;
                                if (w_tcol != 32'd0) w_tcol = w_tcol - 32'd1;
                                else if (WRAP)      w_tcol = f_last_col(w_trow);
                            end
                            SC_RIGHT: if (w_arrow_ok) begin
                                w_nact = ACT_MOVE;
                                if (w_tcol < f_last_col(w_trow)) w_tcol = w_tcol + 32'd1;
                                else if (WRAP)                   w_tcol = 32'd0;
                            end
                            SC_0: w_nact = ACT_DOWN;
                            SC_1, SC_2: begin
                                w_nact = (w_code == SC_1) ? ACT_UP : ACT_AUX;
                                if (w_momentary) begin
                                    w_nstate     = ST_HELD;
                                    w_nheld_key2 = (w_code == SC_2);
                                end
                            end
                            default: ;
                        endcase
                        // A row change may land past the last switch; pull the
                        // column back so the index sits on LAST_INDEX.
                        if (w_trow * COLS + w_tcol > LAST_INDEX)
                            w_tcol = LAST_INDEX - w_trow * COLS;
                    end
                end
                ST_HELD: begin
                    if (!w_make &&
                        (((w_code == SC_1) && !r_held_key2) ||
                         ((w_code == SC_2) &&  r_held_key2))) begin
                        w_nact   = ACT_DOWN;
                        w_nstate = ST_IDLE;
                    end
                end
                default: w_nstate = ST_IDLE;
            endcase
        end
        w_nrow = ROW_W'(w_trow);
        w_ncol = COL_W'(w_tcol);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_row       <= '0;
            r_col       <= '0;
            r_action    <= ACT_MOVE;
            r_state     <= ST_IDLE;
            r_held_key2 <= 1'b0;
            r_strobe    <= 1'b0;
            r_held      <= 1'b0;
        end else begin
            r_row       <= w_nrow;
            r_col       <= w_ncol;
            r_action    <= w_nact;
            r_state     <= w_nstate;
            r_held_key2 <= w_nheld_key2;
            r_strobe    <= (w_nact != r_action) || (w_nidx != w_cur_idx);
            r_held      <= (w_nstate == ST_HELD);
        end
    end

    assign cursor_index  = w_cur_idx;
    assign cursor_row    = r_row;
    assign cursor_col    = r_col;
    assign cursor_action = r_action;
    assign action_strobe = r_strobe;
    assign held          = r_held;

endmodule

// File: tb/tb_panel_cursor.sv
module tb_panel_cursor;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [10:0] ps2_key = 11'h400;
    logic        tog = 1'b1;

    logic [4:0]  idx0, idx1;
    logic        row0, row1;
    logic [3:0]  col0, col1;
    logic [1:0]  act0, act1;
    logic        stb0, stb1;
    logic        hld0, hld1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    panel_cursor #(
        .COLS(16), .ROWS(2), .IDX_W(5), .LAST_INDEX(24),
        .MOMENTARY_MASK(32'h007C_0000), .WRAP(1'b0), .REQUIRE_EXT(1'b1)
    ) dut (
        .clk(clk), .reset_n(reset_n), .ps2_key(ps2_key),
        .cursor_index(idx0), .cursor_row(row0), .cursor_col(col0),
        .cursor_action(act0), .action_strobe(stb0), .held(hld0)
    );

    panel_cursor #(
        .COLS(16), .ROWS(2), .IDX_W(5), .LAST_INDEX(24),
        .MOMENTARY_MASK(32'h007C_0000), .WRAP(1'b1), .REQUIRE_EXT(1'b1)
    ) dut_wrap (
        .clk(clk), .reset_n(reset_n), .ps2_key(ps2_key),
        .cursor_index(idx1), .cursor_row(row1), .cursor_col(col1),
        .cursor_action(act1), .action_strobe(stb1), .held(hld1)
    );

    typedef struct {
        logic [7:0] code;
        logic       ext;
        logic       make;
        int         idx;
        int         act;
        logic       hld;
        logic       stb;
        logic       chk_wrap;
        int         wrap_idx;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Drive one PS/2 event and return #1 after the edge where outputs update.
    task automatic send(input logic [7:0] code, input logic ext, input logic make);
        tog = ~tog;
        ps2_key = {tog, make, ext, code};
        @(posedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_state(input string tag, input int idx, input int act,
                             input logic h, input logic s);
        chk({tag, ".idx"}, int'(idx0), idx);
        chk({tag, ".act"}, int'(act0), act);
        chk({tag, ".held"}, int'(hld0), int'(h));
        chk({tag, ".strobe"}, int'(stb0), int'(s));
    endtask

    function automatic vec_t mk(input logic [7:0] code, input logic ext, input logic make,
                                input int idx, input int act, input logic h, input logic s);
        vec_t v;
        v.code = code; v.ext = ext; v.make = make;
        v.idx = idx; v.act = act; v.hld = h; v.stb = s;
        v.chk_wrap = 1'b0; v.wrap_idx = 0;
        return v;
    endfunction

    task automatic do_reset(input int cycles);
        reset_n = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        vec_t v;

        // down, then right to the end of row 1
        v = mk(8'h72, 1, 1, 16, 3, 0, 1); v.chk_wrap = 1; v.wrap_idx = 16; vecs.push_back(v);
        for (int i = 1; i <= 8; i++) begin
            v = mk(8'h74, 1, 1, 16 + i, 3, 0, 1);
            if (i == 8) begin v.chk_wrap = 1; v.wrap_idx = 24; end
            vecs.push_back(v);
        end
        // ninth right: clamped, wrap instance goes back to column 0
        v = mk(8'h74, 1, 1, 24, 3, 0, 0); v.chk_wrap = 1; v.wrap_idx = 16; vecs.push_back(v);
        vecs.push_back(mk(8'h75, 1, 1, 8, 3, 0, 1));
        for (int i = 1; i <= 6; i++) vecs.push_back(mk(8'h6B, 1, 1, 8 - i, 3, 0, 1));
        // non-extended arrow ignored
        vecs.push_back(mk(8'h74, 0, 1, 2, 3, 0, 0));
        // momentary hold at index 18
        vecs.push_back(mk(8'h72, 1, 1, 18, 3, 0, 1));
        vecs.push_back(mk(8'h16, 0, 1, 18, 1, 1, 1));
        vecs.push_back(mk(8'h6B, 1, 1, 18, 1, 1, 0));
        vecs.push_back(mk(8'h1E, 0, 0, 18, 1, 1, 0));
        vecs.push_back(mk(8'h16, 0, 1, 18, 1, 1, 0));
        vecs.push_back(mk(8'h16, 0, 0, 18, 0, 0, 1));
        // latched (non-momentary) aux at index 23
        for (int i = 1; i <= 5; i++) vecs.push_back(mk(8'h74, 1, 1, 18 + i, 3, 0, 1));
        vecs.push_back(mk(8'h1E, 0, 1, 23, 2, 0, 1));
        vecs.push_back(mk(8'h1E, 0, 0, 23, 2, 0, 0));
        vecs.push_back(mk(8'h45, 0, 0, 23, 2, 0, 0));
        vecs.push_back(mk(8'h45, 0, 1, 23, 0, 0, 1));
        vecs.push_back(mk(8'h45, 0, 1, 23, 0, 0, 0));
        // down at last row: only the action changes; typematic repeat is silent
        vecs.push_back(mk(8'h72, 1, 1, 23, 3, 0, 1));
        vecs.push_back(mk(8'h72, 1, 1, 23, 3, 0, 0));
        // row change past LAST_INDEX clamps the column
        vecs.push_back(mk(8'h75, 1, 1, 7, 3, 0, 1));
        for (int i = 1; i <= 5; i++) vecs.push_back(mk(8'h74, 1, 1, 7 + i, 3, 0, 1));
        vecs.push_back(mk(8'h72, 1, 1, 24, 3, 0, 1));
        vecs.push_back(mk(8'h1C, 0, 1, 24, 3, 0, 0));

        // reset with toggle=1 and a clean release
        ps2_key = {tog, 10'h000};
        do_reset(3);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk_state("reset_exit", 0, 3, 0, 0);
        end

        foreach (vecs[i]) begin
            send(vecs[i].code, vecs[i].ext, vecs[i].make);
            chk_state($sformatf("vec%0d", i), vecs[i].idx, vecs[i].act, vecs[i].hld, vecs[i].stb);
            if (vecs[i].chk_wrap)
                chk($sformatf("vec%0d.wrap_idx", i), int'(idx1), vecs[i].wrap_idx);
            @(posedge clk); #1;
            chk($sformatf("vec%0d.strobe_pulse", i), int'(stb0), 0);
        end

        // reset in the middle of a momentary hold
        do_reset(1);
        @(posedge clk); #1;
        send(8'h72, 1, 1);
        for (int i = 0; i < 3; i++) send(8'h74, 1, 1);
        send(8'h16, 0, 1);
        chk_state("hold19", 19, 1, 1, 1);
        @(posedge clk); #1;
        do_reset(1);
        chk_state("mid_hold_reset", 0, 3, 0, 0);
        @(posedge clk); #1;
        chk_state("post_reset", 0, 3, 0, 0);
        send(8'h16, 0, 0);
        chk_state("stale_break", 0, 3, 0, 0);
        @(posedge clk); #1;
        chk("stale_break.strobe_late", int'(stb0), 0);

        // left at column 0: clamp vs wrap to end of row
        send(8'h6B, 1, 1);
        chk_state("left_at_0", 0, 3, 0, 0);
        chk("left_at_0.wrap_idx", int'(idx1), 15);
        chk("left_at_0.wrap_strobe", int'(stb1), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
